// File: rtl/mem_pkg.sv
// Shared data-memory definitions: access-size encodings and the store-buffer entry layout.
package mem_pkg;

    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  lsc;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular store queue: entry storage, head/tail pointers, occupancy count,
// and a per-entry valid/word-address view for load conflict matching.
module store_buffer_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        push,
    input  sb_entry_t                   push_entry,
    input  logic                        pop,
    output sb_entry_t                   head_entry,
    output logic [CNT_W-1:0]            count,
    output logic [DEPTH-1:0]            ent_valid,
    output logic [DEPTH-1:0][29:0]      ent_word
);

    sb_entry_t          mem_q [DEPTH];
    sb_entry_t          mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads are don't-care while invalid, so they carry no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        ent_valid = '0;
        ent_word  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = {1'b0, PTR_W'(i) - head_q} < count_q;
            ent_word[i]  = mem_q[i].addr[31:2];
        end
    end

    assign head_entry = mem_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/store_buffer.sv
// Write buffer between the MEM stage and the data memory port: loads get the
// port first unless they hit a queued store's word or the buffer is full.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_address,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_lscontrol,
    input  logic        ld_req,
    input  logic [31:0] ld_address,
    input  logic [1:0]  ld_lscontrol,
    output logic        ld_stall,
    output logic        empty,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] address_data,
    output logic [31:0] writedata,
    output logic [1:0]  lscontrol
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t              head_entry;
    sb_entry_t              push_entry;
    logic [PTR_W:0]         count;
    logic [DEPTH-1:0]       ent_valid;
    logic [DEPTH-1:0][29:0] ent_word;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   hit;
    logic                   conflict;

    assign full       = (count == (PTR_W + 1)'(DEPTH));
    assign st_ready   = !full;
    assign empty      = (count == '0);
    assign push       = st_valid && st_ready;
    assign push_entry = '{addr: st_address, data: st_data, lsc: st_lscontrol};

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (count),
        .ent_valid  (ent_valid),
        .ent_word   (ent_word)
    );

    // Word-granular match; the store pushed this cycle is not yet in ent_valid.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_word[i] == ld_address[31:2])) begin
                hit = 1'b1;
            end
        end
        conflict = ld_req && hit;
    end

    always_comb begin
        memread      = 1'b0;
        memwrite     = 1'b0;
        address_data = '0;
        writedata    = '0;
        lscontrol    = LS_WORD;
        ld_stall     = ld_req;
        pop          = 1'b0;
        if (full || !(ld_req && !conflict && !st_valid)) begin
            if (count != '0) begin
                memwrite     = 1'b1;
                address_data = head_entry.addr;
                writedata    = head_entry.data;
                lscontrol    = head_entry.lsc;
                pop          = 1'b1;
            end
        end else begin
            memread      = 1'b1;
            address_data = ld_address;
            lscontrol    = ld_lscontrol;
            ld_stall     = 1'b0;
        end
    end

endmodule
